// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences each instruction through fetch/decode/execute/memory/write-back
// and drives the datapath enables, with optional memory handshake, illegal-op trap and retire counter.
module multicycle_control #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_ILLEGAL  = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Op,
  input  logic [5:0]       Fun,
  input  logic             equal,
  input  logic             sign,
  input  logic             mem_ready,
  output logic             PCWr,
  output logic [1:0]       PCSrc,
  output logic             IorD,
  output logic             MemRd,
  output logic             MemWr,
  output logic             IRWr,
  output logic             RegWr,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             ExtOp,
  output logic [2:0]       ALUctr,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  state_t state_q, state_d;
  logic   r_ok;
  logic [2:0] r_alu;
  logic   pcwr_c, memrd_c, memwr_c, irwr_c, regwr_c;
  logic   mem_done;

  // With the handshake disabled every memory state completes in one cycle.
  assign mem_done = !MEM_HANDSHAKE || mem_ready;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    unique case (Fun)
      6'b100000, 6'b100001: r_alu = ALU_ADD;
      6'b100010, 6'b100011: r_alu = ALU_SUB;
      6'b100100:            r_alu = ALU_AND;
      6'b100101:            r_alu = ALU_OR;
      6'b101010:            r_alu = ALU_SLT;
      default:              r_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pcwr_c   = 1'b0;
    memrd_c  = 1'b0;
    memwr_c  = 1'b0;
    irwr_c   = 1'b0;
    regwr_c  = 1'b0;
    PCSrc    = 2'b00;
    IorD     = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ExtOp    = 1'b0;
    ALUctr   = ALU_ADD;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memrd_c = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_done) begin
          irwr_c  = 1'b1;
          pcwr_c  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
        if (Op == OP_R && r_ok)                        state_d = S_EXEC_R;
        else if (Op == OP_ORI || Op == OP_ADDIU)       state_d = S_EXEC_I;
        else if (Op == OP_LW || Op == OP_SW)           state_d = S_MEM_ADDR;
        else if (Op == OP_BEQ || Op == OP_BNE || Op == OP_BLTZ) state_d = S_BRANCH;
        else if (Op == OP_J)                           state_d = S_JUMP;
        else state_d = TRAP_ILLEGAL ? S_TRAP : S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUctr  = r_alu;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        regwr_c = 1'b1;
        RegDst  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = (Op != OP_ORI);
        ALUctr  = (Op == OP_ORI) ? ALU_OR : ALU_ADD;
        state_d = S_WB_I;
      end
      S_WB_I: begin
        regwr_c = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
        state_d = (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        memrd_c = 1'b1;
        IorD    = 1'b1;
        if (mem_done) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        regwr_c  = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        memwr_c = 1'b1;
        IorD    = 1'b1;
        if (mem_done) state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUctr  = ALU_SUB;
        PCSrc   = 2'b01;
        case (Op)
          OP_BEQ:  pcwr_c = equal;
          OP_BNE:  pcwr_c = !equal;
          OP_BLTZ: pcwr_c = sign;
          default: pcwr_c = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcwr_c  = 1'b1;
        PCSrc   = 2'b10;
        state_d = S_FETCH;
      end
      S_TRAP: illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked by reset so an in-flight memory access drops without waiting for a clock.
  assign PCWr  = pcwr_c  & rst_n;
  assign MemRd = memrd_c & rst_n;
  assign MemWr = memwr_c & rst_n;
  assign IRWr  = irwr_c  & rst_n;
  assign RegWr = regwr_c & rst_n;
  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instr_count <= '0;
    else if (state_q != S_FETCH && state_d == S_FETCH)
      instr_count <= instr_count + CNT_W'(1);
  end

endmodule
